pc_stack_control: RTL and testbench

- Owns the 12-bit program counter and the subroutine return-address stack.
- Drives the fetch address onto the 4-bit bus as three nibbles during subcycles 0–2 of each 8-subcycle instruction cycle.
- Applies sequential increment, absolute jump, page-relative jump, call and return requests from the instruction decoder.
- Sits beside the decode/control unit and shares its `cycle` counter.

---
 rtl/pc_stack_control.sv | 115 +++++++++++
 tb/tb_pc_stack_control.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_control.sv
// Program counter and return-address ring stack. The PC is driven onto the
// 4-bit bus as three nibbles and is updated once per 8-subcycle instruction.
module pc_stack_control #(
  parameter int          STACK_DEPTH = 3,
  parameter logic [11:0] RESET_PC    = 12'h000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  cycle,
  input  logic        pc_inc,
  input  logic        jump,
  input  logic        jump_page,
  input  logic        call,
  input  logic        ret,
  input  logic [11:0] target,
  output logic [3:0]  addr_nibble,
  output logic        addr_valid,
  output logic [11:0] pc,
  output logic [1:0]  stack_depth,
  output logic        stack_overflow,
  output logic        stack_underflow
);

  localparam int            PW   = (STACK_DEPTH <= 2) ? 1 : $clog2(STACK_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(STACK_DEPTH - 1);
  localparam logic [1:0]    FULL = 2'(STACK_DEPTH);

  logic [11:0]   r_pc;
  logic [11:0]   r_stack [STACK_DEPTH];
  logic [PW-1:0] r_wp;
  logic [1:0]    r_depth;
  logic          r_overflow;
  logic          r_underflow;

  logic [11:0]   w_pc_plus1;
  logic [PW-1:0] w_wp_inc;
  logic [PW-1:0] w_wp_dec;
  logic          w_sample;
  logic [11:0]   w_pc_next;
  logic [PW-1:0] w_wp_next;
  logic [1:0]    w_depth_next;
  logic          w_push;
  logic          w_overflow;
  logic          w_underflow;

  assign w_pc_plus1 = r_pc + 12'd1;
  assign w_wp_inc   = (r_wp == LAST) ? '0 : r_wp + PW'(1);
  assign w_wp_dec   = (r_wp == '0) ? LAST : r_wp - PW'(1);
  assign w_sample   = (cycle == 3'd7);

  // One action per instruction, chosen by fixed priority ret > call > jump > jump_page > pc_inc.
  always_comb begin
    w_pc_next    = r_pc;
    w_wp_next    = r_wp;
    w_depth_next = r_depth;
    w_push       = 1'b0;
    w_overflow   = 1'b0;
    w_underflow  = 1'b0;
    if (w_sample) begin
      if (ret) begin
        w_wp_next = w_wp_dec;
        w_pc_next = r_stack[w_wp_dec];
        if (r_depth == 2'd0) w_underflow  = 1'b1;
        else                 w_depth_next = r_depth - 2'd1;
      end else if (call) begin
        w_push    = 1'b1;
        w_wp_next = w_wp_inc;
        w_pc_next = target;
        if (r_depth == FULL) w_overflow   = 1'b1;
        else                 w_depth_next = r_depth + 2'd1;
      end else if (jump) begin
        w_pc_next = target;
      end else if (jump_page) begin
        w_pc_next = {w_pc_plus1[11:8], target[7:0]};
      end else if (pc_inc) begin
        w_pc_next = w_pc_plus1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_wp        <= '0;
      r_depth     <= 2'd0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= 12'h000;
    end else begin
      r_pc        <= w_pc_next;
      r_wp        <= w_wp_next;
      r_depth     <= w_depth_next;
      r_overflow  <= w_overflow;
      r_underflow <= w_underflow;
      if (w_push) r_stack[r_wp] <= w_pc_plus1;
    end
  end

  always_comb begin
    addr_nibble = 4'h0;
    case (cycle)
      3'd0:    addr_nibble = r_pc[3:0];
      3'd1:    addr_nibble = r_pc[7:4];
      3'd2:    addr_nibble = r_pc[11:8];
      default: addr_nibble = 4'h0;
    endcase
  end

  assign addr_valid      = (cycle <= 3'd2);
  assign pc              = r_pc;
  assign stack_depth     = r_depth;
  assign stack_overflow  = r_overflow;
  assign stack_underflow = r_underflow;

endmodule

// File: tb/tb_pc_stack_control.sv
// Randomized and directed bench for pc_stack_control against a behavioural
// model of the PC and return stack.
module tb_pc_stack_control;

  localparam int          DEPTH = 3;
  localparam logic [11:0] RPC   = 12'h000;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  cycle;
  logic        pc_inc, jump, jump_page, call, ret;
  logic [11:0] target;
  logic [3:0]  addr_nibble;
  logic        addr_valid;
  logic [11:0] pc;
  logic [1:0]  stack_depth;
  logic        stack_overflow, stack_underflow;

  pc_stack_control #(.STACK_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .cycle(cycle),
    .pc_inc(pc_inc), .jump(jump), .jump_page(jump_page), .call(call), .ret(ret),
    .target(target), .addr_nibble(addr_nibble), .addr_valid(addr_valid),
    .pc(pc), .stack_depth(stack_depth),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: integer PC, return ring addressed with modulo arithmetic.
  int m_pc;
  int m_mem [DEPTH];
  int m_wp;
  int m_depth;
  bit m_ovf, m_unf;

  function automatic void model_reset();
    m_pc = int'(RPC);
    foreach (m_mem[i]) m_mem[i] = 0;
    m_wp = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
  endfunction

  function automatic void model_step(bit r, bit c, bit j, bit jp, bit inc, int tgt);
    m_ovf = 0; m_unf = 0;
    if (r) begin
      m_wp = (m_wp + DEPTH - 1) % DEPTH;
      m_pc = m_mem[m_wp];
      if (m_depth == 0) m_unf = 1; else m_depth--;
    end else if (c) begin
      m_mem[m_wp] = (m_pc + 1) % 4096;
      m_wp = (m_wp + 1) % DEPTH;
      m_pc = tgt;
      if (m_depth == DEPTH) m_ovf = 1; else m_depth++;
    end else if (j) begin
      m_pc = tgt;
    end else if (jp) begin
      m_pc = (((m_pc + 1) % 4096) / 256) * 256 + (tgt % 256);
    end else if (inc) begin
      m_pc = (m_pc + 1) % 4096;
    end
  endfunction

  task automatic set_req(bit r, bit c, bit j, bit jp, bit inc, logic [11:0] tgt);
    ret = r; call = c; jump = j; jump_page = jp; pc_inc = inc; target = tgt;
  endtask

  task automatic check_cycle(int k);
    int exp_nib;
    exp_nib = (k <= 2) ? ((m_pc >> (4 * k)) & 15) : 0;
    check("addr_nibble", 32'(addr_nibble), 32'(exp_nib));
    check("addr_valid", 32'(addr_valid), 32'(k <= 2));
    check("pc", 32'(pc), 32'(m_pc));
    check("depth", 32'(stack_depth), 32'(m_depth));
    if (k == 0) begin
      check("overflow", 32'(stack_overflow), 32'(m_ovf));
      check("underflow", 32'(stack_underflow), 32'(m_unf));
    end else begin
      check("overflow_clr", 32'(stack_overflow), 32'(0));
      check("underflow_clr", 32'(stack_underflow), 32'(0));
    end
  endtask

  // One instruction: requests applied at cycle 7, random noise elsewhere.
  task automatic instr(bit r, bit c, bit j, bit jp, bit inc, logic [11:0] tgt, bit noise);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      cycle = 3'(k);
      if (k == 7) set_req(r, c, j, jp, inc, tgt);
      else if (noise) set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)));
      else set_req(0, 0, 0, 0, 0, 12'h000);
      #1;
      check_cycle(k);
    end
    model_step(r, c, j, jp, inc, int'(tgt));
  endtask

  task automatic expect_after(input string tag, input logic [11:0] exp_pc, input logic [1:0] exp_d);
    @(posedge clock); #1;
    check({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    check({tag, "_depth"}, 32'(stack_depth), 32'(exp_d));
  endtask

  // Reset pulse at cycle 4 while a call is held.
  task automatic reset_mid();
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k == 5) model_reset();
      cycle = 3'(k);
      reset = (k == 4);
      if (k >= 3 && k <= 6) set_req(0, 1, 0, 0, 0, 12'h777);
      else set_req(0, 0, 0, 0, 0, 12'h000);
      #1;
      if (k != 4) check_cycle(k);
    end
    reset = 1'b0;
    model_step(0, 0, 0, 0, 0, 0);
    check("rst_mid_pc", 32'(pc), 32'(RPC));
    check("rst_mid_depth", 32'(stack_depth), 32'(0));
  endtask

  initial begin
    reset = 1'b1; cycle = 3'd0;
    set_req(0, 0, 0, 0, 0, 12'h000);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_pc", 32'(pc), 32'(RPC));
    check("reset_depth", 32'(stack_depth), 32'(0));
    check("reset_ovf", 32'(stack_overflow), 32'(0));
    @(negedge clock);
    reset = 1'b0;

    // Sequential increment.
    repeat (3) instr(0, 0, 0, 0, 1, 12'h000, 1);
    expect_after("inc3", 12'h003, 2'd0);
    instr(0, 0, 0, 0, 0, 12'h000, 1);

    // Page-relative jumps, including page carry.
    instr(0, 0, 1, 0, 0, 12'h2FF, 1);
    instr(0, 0, 0, 1, 0, 12'h045, 1);
    expect_after("jpage_carry", 12'h345, 2'd0);
    instr(0, 0, 1, 0, 0, 12'h210, 1);
    instr(0, 0, 0, 1, 0, 12'h045, 1);
    expect_after("jpage", 12'h245, 2'd0);
    instr(0, 0, 1, 0, 0, 12'hFFF, 1);
    instr(0, 0, 0, 0, 1, 12'h000, 1);
    expect_after("wrap", 12'h000, 2'd0);

    // Nested call / return.
    instr(0, 0, 1, 0, 0, 12'h100, 1);
    instr(0, 1, 0, 0, 0, 12'h400, 1); expect_after("call1", 12'h400, 2'd1);
    instr(0, 1, 0, 0, 0, 12'h500, 1); expect_after("call2", 12'h500, 2'd2);
    instr(1, 0, 0, 0, 0, 12'h000, 1); expect_after("ret1", 12'h401, 2'd1);
    instr(1, 0, 0, 0, 0, 12'h000, 1); expect_after("ret2", 12'h101, 2'd0);

    // Overflow on 4th call, underflow on 4th return.
    instr(0, 0, 1, 0, 0, 12'h010, 1);
    instr(0, 1, 0, 0, 0, 12'h020, 1);
    instr(0, 1, 0, 0, 0, 12'h030, 1);
    instr(0, 1, 0, 0, 0, 12'h040, 1);
    instr(0, 1, 0, 0, 0, 12'h050, 1);
    expect_after("ovf_call", 12'h050, 2'd3);
    check("ovf_pulse", 32'(stack_overflow), 32'(1));
    instr(1, 0, 0, 0, 0, 12'h000, 1); expect_after("ovf_ret1", 12'h041, 2'd2);
    instr(1, 0, 0, 0, 0, 12'h000, 1); expect_after("ovf_ret2", 12'h031, 2'd1);
    instr(1, 0, 0, 0, 0, 12'h000, 1); expect_after("ovf_ret3", 12'h021, 2'd0);
    instr(1, 0, 0, 0, 0, 12'h000, 1);
    @(posedge clock); #1;
    check("unf_pulse", 32'(stack_underflow), 32'(1));

    // ret beats pc_inc.
    instr(0, 0, 1, 0, 0, 12'h0AA, 1);
    instr(0, 1, 0, 0, 0, 12'h123, 1);
    instr(1, 0, 0, 0, 1, 12'h000, 1);
    expect_after("ret_prio", 12'h0AB, 2'd0);
    instr(0, 0, 0, 0, 0, 12'h000, 1);

    // Reset mid-instruction with a pending call.
    instr(0, 1, 0, 0, 0, 12'h3C3, 1);
    reset_mid();

    // Random instruction stream.
    for (int n = 0; n < 300; n++)
      instr(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), 1);
    instr(0, 0, 0, 0, 0, 12'h000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
